// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM march BIST controller.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } bist_state_t;

    // Test pattern for an address: zero-extended address xor seed, optionally inverted.
    // Callers truncate the result to the RAM word width.
    function automatic logic [31:0] pat(input logic [31:0] addr,
                                        input logic [31:0] seed,
                                        input logic        inv);
        logic [31:0] p;
        p = addr ^ seed;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-compare pipeline: registers each issued read, then compares the RAM
// output against the expected pattern one cycle later. Keeps the miscompare
// count and the first failing address.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  issue_inv,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    logic                  cmp_valid;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  cmp_inv;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  miscompare;

    // Expected word for the read that is landing on mem_data_out this cycle.
    always_comb begin
        exp_data   = DATA_WIDTH'(pat(32'(cmp_addr), 32'(SEED), cmp_inv));
        miscompare = cmp_valid && (mem_data_out != exp_data);
    end

    // Compare pipe: capture the read issued this cycle for checking next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_inv   <= 1'b0;
        end else if (clear) begin
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_inv   <= 1'b0;
        end else begin
            cmp_valid <= issue_valid;
            cmp_addr  <= issue_addr;
            cmp_inv   <= issue_inv;
        end
    end

    // Error accounting; fail_addr latches only on the first miscompare of a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            fail_addr <= '0;
        end else if (clear) begin
            err_count <= '0;
            fail_addr <= '0;
        end else if (miscompare) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
                fail_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: rtl/ram_bist_controller.sv
// March BIST engine for a single-port synchronous-read RAM.
//
// state | meaning
// IDLE  | waiting for start, RAM port quiet
// WR0   | write P(a) to every address
// RD0   | read every address and compare to P(a), plus one drain cycle
// WR1   | write ~P(a) to every address
// RD1   | read every address and compare to ~P(a), plus one drain cycle
// DONE  | results valid, waiting for start
module ram_bist_controller
    import ram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    bist_state_t           state_q;
    bist_state_t           state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  drain_q;
    logic                  start_accept;
    logic                  issue_valid;
    logic                  issue_inv;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; write phases end on the last address, read phases after the drain cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = WR0;
            WR0:        if (addr_q == LAST_ADDR) state_d = RD0;
            RD0:        if (drain_q) state_d = WR1;
            WR1:        if (addr_q == LAST_ADDR) state_d = RD1;
            RD1:        if (drain_q) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Address counter; in read phases it parks on the last address for the drain cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            unique case (state_q)
                WR0, WR1: begin
                    addr_q  <= addr_q + 1'b1;
                    drain_q <= 1'b0;
                end
                RD0, RD1: begin
                    if (drain_q) begin
                        addr_q  <= '0;
                        drain_q <= 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
                        drain_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: begin
                    addr_q  <= '0;
                    drain_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs and RAM port drive decoded from the current state.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        pass         = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        issue_valid  = 1'b0;
        issue_inv    = 1'b0;
        unique case (state_q)
            WR0, WR1: begin
                busy         = 1'b1;
                mem_write_en = 1'b1;
                mem_address  = addr_q;
                mem_data_in  = DATA_WIDTH'(pat(32'(addr_q), 32'(SEED), state_q == WR1));
            end
            RD0, RD1: begin
                busy        = 1'b1;
                mem_address = addr_q;
                issue_valid = !drain_q;
                issue_inv   = (state_q == RD1);
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
            end
            default: ;
        endcase
    end

    ram_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start_accept),
        .issue_valid  (issue_valid),
        .issue_addr   (addr_q),
        .issue_inv    (issue_inv),
        .mem_data_out (mem_data_out),
        .err_count    (err_count),
        .fail_addr    (fail_addr)
    );

endmodule
